id_stage_pipe: RTL and testbench

- Registered, handshaked RV32I decode stage; replaces the combinational decoder plus the separate id_ex register.
- Sits between if_id and ex, and reads the register file combinationally.
- Adds a writeback bypass, load-use stall, branch flush, LOAD/STORE decode and illegal-instruction flagging.
- Data width is parametrised.

---
 rtl/id_stage_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with bypass, load-use stall and flush
module id_stage_pipe #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            fwd_wen_i,
    input  logic [4:0]      fwd_rd_i,
    input  logic [XLEN-1:0] fwd_data_i,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen_o,
    output logic [XLEN-1:0] base_addr_o,
    output logic [XLEN-1:0] offset_addr_o,
    output logic            mem_ren_o,
    output logic            mem_wen_o,
    output logic            illegal_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd_f   = inst_i[11:7];
    assign rs1_f  = inst_i[19:15];
    assign rs2_f  = inst_i[24:20];
    assign imm_i  = sext({{20{inst_i[31]}}, inst_i[31:20]});
    assign imm_s  = sext({{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]});
    assign imm_b  = sext({{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
    assign imm_j  = sext({{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});
    assign imm_u  = sext({inst_i[31:12], 12'b0});

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_ialu, is_ralu;
    logic use_rs1, use_rs2, is_illegal, is_shift;

    // classify the incoming instruction; unsupported opcode/func3 leaves every class low
    always_comb begin
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_ialu   = 1'b0;
        is_ralu   = 1'b0;
        case (opcode)
            OP_LUI:    is_lui    = 1'b1;
            OP_AUIPC:  is_auipc  = 1'b1;
            OP_JAL:    is_jal    = 1'b1;
            OP_JALR:   is_jalr   = 1'b1;
            OP_BRANCH: is_branch = (funct3 != 3'd2) && (funct3 != 3'd3);
            OP_LOAD:   is_load   = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            OP_STORE:  is_store  = (funct3 <= 3'd2);
            OP_IALU:   is_ialu   = 1'b1;
            OP_RALU:   is_ralu   = 1'b1;
            default:   ;
        endcase
    end

    assign use_rs1    = is_ialu | is_ralu | is_branch | is_jalr | is_load | is_store;
    assign use_rs2    = is_ralu | is_branch | is_store;
    assign is_illegal = ~(use_rs1 | is_lui | is_auipc | is_jal);
    assign is_shift   = (funct3[1:0] == 2'b01);
    assign rs1_addr_o = use_rs1 ? rs1_f : 5'd0;
    assign rs2_addr_o = use_rs2 ? rs2_f : 5'd0;

    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1_addr_o == 5'd0) ? '0 :
                     (fwd_wen_i && fwd_rd_i == rs1_addr_o) ? fwd_data_i : rs1_data_i;
    assign rs2_val = (rs2_addr_o == 5'd0) ? '0 :
                     (fwd_wen_i && fwd_rd_i == rs2_addr_o) ? fwd_data_i : rs2_data_i;

    logic [XLEN-1:0] d_op1, d_op2, d_base, d_off;
    logic [4:0]      d_rd;
    logic            d_wen, d_mren, d_mwen;

    // per-format operand, address and control selection; illegal keeps all fields zero
    always_comb begin
        d_op1  = '0;
        d_op2  = '0;
        d_base = '0;
        d_off  = '0;
        d_rd   = 5'd0;
        d_wen  = 1'b0;
        d_mren = 1'b0;
        d_mwen = 1'b0;
        if (is_ialu) begin
            d_op1 = rs1_val;
            d_op2 = is_shift ? XLEN'(rs2_f) : imm_i;
            d_rd  = rd_f;
            d_wen = 1'b1;
        end else if (is_ralu) begin
            d_op1 = rs1_val;
            d_op2 = is_shift ? XLEN'(rs2_val[4:0]) : rs2_val;
            d_rd  = rd_f;
            d_wen = 1'b1;
        end else if (is_branch) begin
            d_op1  = rs1_val;
            d_op2  = rs2_val;
            d_base = inst_addr_i;
            d_off  = imm_b;
        end else if (is_jal || is_jalr) begin
            d_op1  = inst_addr_i;
            d_op2  = XLEN'(4);
            d_base = is_jal ? inst_addr_i : rs1_val;
            d_off  = is_jal ? imm_j : imm_i;
            d_rd   = rd_f;
            d_wen  = 1'b1;
        end else if (is_lui || is_auipc) begin
            d_op1 = imm_u;
            d_op2 = is_auipc ? inst_addr_i : '0;
            d_rd  = rd_f;
            d_wen = 1'b1;
        end else if (is_load) begin
            d_base = rs1_val;
            d_off  = imm_i;
            d_rd   = rd_f;
            d_wen  = 1'b1;
            d_mren = 1'b1;
        end else if (is_store) begin
            d_op2  = rs2_val;
            d_base = rs1_val;
            d_off  = imm_s;
            d_mwen = 1'b1;
        end
    end

    logic       trk_valid;
    logic [4:0] trk_rd;
    logic       stall, accept, load_handoff;

    assign stall        = trk_valid && ((rs1_addr_o == trk_rd) || (rs2_addr_o == trk_rd));
    assign in_ready     = (!out_valid || out_ready) && !stall && !flush_i;
    assign accept       = in_valid && in_ready;
    assign load_handoff = out_valid && out_ready && mem_ren_o && (rd_addr_o != 5'd0);

    // remember a load's destination for the one cycle after ex takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid <= 1'b0;
            trk_rd    <= 5'd0;
        end else begin
            trk_valid <= load_handoff && !flush_i;
            trk_rd    <= rd_addr_o;
        end
    end

    // output register: flush kills, accept loads, a consumed entry empties to NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            inst_o        <= NOP_INST;
            inst_addr_o   <= '0;
            op1_o         <= '0;
            op2_o         <= '0;
            rd_addr_o     <= 5'd0;
            reg_wen_o     <= 1'b0;
            base_addr_o   <= '0;
            offset_addr_o <= '0;
            mem_ren_o     <= 1'b0;
            mem_wen_o     <= 1'b0;
            illegal_o     <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            inst_o    <= NOP_INST;
        end else if (accept) begin
            out_valid     <= 1'b1;
            inst_o        <= inst_i;
            inst_addr_o   <= inst_addr_i;
            op1_o         <= d_op1;
            op2_o         <= d_op2;
            rd_addr_o     <= d_rd;
            reg_wen_o     <= d_wen;
            base_addr_o   <= d_base;
            offset_addr_o <= d_off;
            mem_ren_o     <= d_mren;
            mem_wen_o     <= d_mwen;
            illegal_o     <= is_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            inst_o    <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - bench for id_stage_pipe: vector table, corner sequences, random vs model
module tb_id_stage_pipe;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, fwd_wen_i, flush_i, out_valid, out_ready;
    logic [31:0] inst_i, inst_addr_i, rs1_data_i, rs2_data_i, fwd_data_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o, fwd_rd_i, rd_addr_o;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, offset_addr_o;
    logic        reg_wen_o, mem_ren_o, mem_wen_o, illegal_o;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fwd_wen_i(fwd_wen_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o),
        .base_addr_o(base_addr_o), .offset_addr_o(offset_addr_o),
        .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [31:0] inst, pc, op1, op2, base, off;
        logic [4:0]  rd, rs1a, rs2a;
        logic        wen, mren, mwen, ill;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] inst, pc, r1, r2;
        logic        fw;
        logic [4:0]  frd;
        logic [31:0] fd, op1, op2, base, off;
        logic [4:0]  rd;
        logic        wen, mren, mwen, ill;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, ".inst"}, inst_o, e.inst);
        chk({tag, ".pc"}, inst_addr_o, e.pc);
        chk({tag, ".op1"}, op1_o, e.op1);
        chk({tag, ".op2"}, op2_o, e.op2);
        chk({tag, ".base"}, base_addr_o, e.base);
        chk({tag, ".off"}, offset_addr_o, e.off);
        chk({tag, ".rd"}, 32'(rd_addr_o), 32'(e.rd));
        chk({tag, ".wen"}, 32'(reg_wen_o), 32'(e.wen));
        chk({tag, ".mren"}, 32'(mem_ren_o), 32'(e.mren));
        chk({tag, ".mwen"}, 32'(mem_wen_o), 32'(e.mwen));
        chk({tag, ".ill"}, 32'(illegal_o), 32'(e.ill));
    endtask

    // reference decode from the instruction-set rules, immediates built arithmetically
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic fw, input logic [4:0] frd, input logic [31:0] fd);
        exp_t e;
        string k;
        logic signed [31:0] s;
        logic [31:0] ii, is_, ib, ij, iu, v1, v2;
        int f3;
        s   = $signed(ins);
        f3  = int'(ins[14:12]);
        ii  = 32'(s >>> 20);
        is_ = 32'(s >>> 25) * 32 + 32'(ins[11:7]);
        ib  = 32'(s >>> 31) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
        ij  = 32'(s >>> 31) * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
        iu  = ins & 32'hFFFF_F000;
        case (ins[6:0])
            7'h13:   k = "ialu";
            7'h33:   k = "ralu";
            7'h63:   k = (f3 == 2 || f3 == 3) ? "ill" : "br";
            7'h6F:   k = "jal";
            7'h67:   k = "jalr";
            7'h37:   k = "lui";
            7'h17:   k = "auipc";
            7'h03:   k = (f3 == 3 || f3 >= 6) ? "ill" : "load";
            7'h23:   k = (f3 <= 2) ? "store" : "ill";
            default: k = "ill";
        endcase
        e = '{inst: ins, pc: pc, op1: 0, op2: 0, base: 0, off: 0, rd: 0, rs1a: 0, rs2a: 0,
              wen: 0, mren: 0, mwen: 0, ill: 0};
        if (k inside {"ialu", "ralu", "br", "jalr", "load", "store"}) e.rs1a = ins[19:15];
        if (k inside {"ralu", "br", "store"}) e.rs2a = ins[24:20];
        v1 = (e.rs1a == 0) ? 0 : (fw && frd == e.rs1a) ? fd : r1;
        v2 = (e.rs2a == 0) ? 0 : (fw && frd == e.rs2a) ? fd : r2;
        if (k inside {"ialu", "ralu", "jal", "jalr", "lui", "auipc", "load"}) begin
            e.rd  = ins[11:7];
            e.wen = 1;
        end
        case (k)
            "ialu":  begin e.op1 = v1; e.op2 = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ii; end
            "ralu":  begin e.op1 = v1; e.op2 = (f3 == 1 || f3 == 5) ? v2 % 32 : v2; end
            "br":    begin e.op1 = v1; e.op2 = v2; e.base = pc; e.off = ib; end
            "jal":   begin e.op1 = pc; e.op2 = 4; e.base = pc; e.off = ij; end
            "jalr":  begin e.op1 = pc; e.op2 = 4; e.base = v1; e.off = ii; end
            "lui":   e.op1 = iu;
            "auipc": begin e.op1 = iu; e.op2 = pc; end
            "load":  begin e.base = v1; e.off = ii; e.mren = 1; end
            "store": begin e.base = v1; e.off = is_; e.op2 = v2; e.mwen = 1; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0] op;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: op = 7'h13;  1: op = 7'h33;  2: op = 7'h63;  3: op = 7'h6F;
            4: op = 7'h67;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h03;
            8: op = 7'h23;  9: op = 7'h7F;  default: op = 7'h03;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic idle();
        in_valid = 0; out_ready = 1; flush_i = 0; fwd_wen_i = 0; fwd_rd_i = 0; fwd_data_i = 0;
        inst_i = NOP; inst_addr_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    endtask

    task automatic drain();
        idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];
    exp_t e, d, m_exp;
    logic m_ov, m_trk_v, nt_v, stall, rdy;
    logic [4:0] m_trk_rd, nt_rd;

    initial begin
        vecs[0]  = '{"addi_x0fwd", 32'hFFB00093, 32'h100, 32'h55, 32'h0, 1, 5'd0, 32'hDEAD,
                     32'h0, 32'hFFFFFFFB, 32'h0, 32'h0, 5'd1, 1, 0, 0, 0};
        vecs[1]  = '{"add_fwd", 32'h002081B3, 32'h104, 32'h22, 32'h11, 1, 5'd2, 32'hAA,
                     32'h22, 32'hAA, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0};
        vecs[2]  = '{"slli", 32'h00709213, 32'h108, 32'h33, 32'h0, 0, 5'd0, 32'h0,
                     32'h33, 32'h7, 32'h0, 32'h0, 5'd4, 1, 0, 0, 0};
        vecs[3]  = '{"lui", 32'hABCDE2B7, 32'h10C, 32'h1, 32'h2, 0, 5'd0, 32'h0,
                     32'hABCDE000, 32'h0, 32'h0, 32'h0, 5'd5, 1, 0, 0, 0};
        vecs[4]  = '{"auipc", 32'h12345317, 32'h200, 32'h1, 32'h2, 0, 5'd0, 32'h0,
                     32'h12345000, 32'h200, 32'h0, 32'h0, 5'd6, 1, 0, 0, 0};
        vecs[5]  = '{"lw", 32'h0080A283, 32'h204, 32'h1000, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h1000, 32'h8, 5'd5, 1, 1, 0, 0};
        vecs[6]  = '{"sw", 32'hFE20AE23, 32'h208, 32'h2000, 32'h77, 0, 5'd0, 32'h0,
                     32'h0, 32'h77, 32'h2000, 32'hFFFFFFFC, 5'd0, 0, 0, 1, 0};
        vecs[7]  = '{"ill_op", 32'h0000007F, 32'h20C, 32'h9, 32'h9, 0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1};
        vecs[8]  = '{"ill_br", 32'h0020A063, 32'h210, 32'h9, 32'h9, 0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1};
        vecs[9]  = '{"jal", 32'h008000EF, 32'h300, 32'h9, 32'h9, 0, 5'd0, 32'h0,
                     32'h300, 32'h4, 32'h300, 32'h8, 5'd1, 1, 0, 0, 0};
        vecs[10] = '{"bne", 32'hFE209CE3, 32'h400, 32'h5, 32'h6, 0, 5'd0, 32'h0,
                     32'h5, 32'h6, 32'h400, 32'hFFFFFFF8, 5'd0, 0, 0, 0, 0};
        vecs[11] = '{"sra", 32'h4020D3B3, 32'h404, 32'h9, 32'h123, 0, 5'd0, 32'h0,
                     32'h9, 32'h3, 32'h0, 32'h0, 5'd7, 1, 0, 0, 0};
        vecs[12] = '{"jalr", 32'h004100E7, 32'h500, 32'h800, 32'h0, 0, 5'd0, 32'h0,
                     32'h500, 32'h4, 32'h800, 32'h4, 5'd1, 1, 0, 0, 0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.inst", inst_o, NOP);
        chk("rst.op1", op1_o, 0);
        chk("rst.wen", 32'(reg_wen_o), 0);
        rst_n = 1;

        // table: one accept per vector, checked one cycle later
        for (int i = 0; i < 13; i++) begin
            inst_i = vecs[i].inst; inst_addr_i = vecs[i].pc;
            rs1_data_i = vecs[i].r1; rs2_data_i = vecs[i].r2;
            fwd_wen_i = vecs[i].fw; fwd_rd_i = vecs[i].frd; fwd_data_i = vecs[i].fd;
            in_valid = 1;
            #1;
            chk({vecs[i].nm, ".ready"}, 32'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 0;
            e = '{inst: vecs[i].inst, pc: vecs[i].pc, op1: vecs[i].op1, op2: vecs[i].op2,
                  base: vecs[i].base, off: vecs[i].off, rd: vecs[i].rd, rs1a: 0, rs2a: 0,
                  wen: vecs[i].wen, mren: vecs[i].mren, mwen: vecs[i].mwen, ill: vecs[i].ill};
            chk({vecs[i].nm, ".valid"}, 32'(out_valid), 1);
            chk_fields(vecs[i].nm, e);
        end

        // load-use: LW handed to ex, then dependent ADD waits exactly one cycle
        drain();
        inst_i = 32'h0080A283; rs1_data_i = 32'h1000; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("lu.lw_mren", 32'(mem_ren_o), 1);
        @(posedge clk); #1;
        inst_i = 32'h00028333; in_valid = 1;
        #1;
        chk("lu.stall", 32'(in_ready), 0);
        chk("lu.rs1addr", 32'(rs1_addr_o), 5);
        @(posedge clk); #1;
        chk("lu.bubble", 32'(out_valid), 0);
        chk("lu.ready_again", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("lu.add_valid", 32'(out_valid), 1);
        chk("lu.add_inst", inst_o, 32'h00028333);
        chk("lu.add_mren", 32'(mem_ren_o), 0);

        // backpressure: BEQ held three cycles, next instruction accepted on release
        drain();
        inst_i = 32'h00208463; inst_addr_i = 32'h500; rs1_data_i = 5; rs2_data_i = 5;
        in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        inst_i = 32'hFFB00093; inst_addr_i = 32'h504;
        for (int k = 0; k < 3; k++) begin
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            #1;
            chk("bp.ready", 32'(in_ready), 0);
            chk("bp.valid", 32'(out_valid), 1);
            chk("bp.inst", inst_o, 32'h00208463);
            chk("bp.op1", op1_o, 5);
            chk("bp.off", offset_addr_o, 8);
            chk("bp.base", base_addr_o, 32'h500);
            @(posedge clk); #1;
        end
        out_ready = 1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp.next_inst", inst_o, 32'hFFB00093);
        chk("bp.next_op2", op2_o, 32'hFFFFFFFB);

        // flush beats accept and kills the held instruction
        drain();
        inst_i = 32'hFFB00093; in_valid = 1;
        @(posedge clk); #1;
        chk("fl.pre_valid", 32'(out_valid), 1);
        inst_i = 32'h00100113; flush_i = 1; out_ready = 0;
        #1;
        chk("fl.ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush_i = 0; in_valid = 0; out_ready = 1;
        chk("fl.valid", 32'(out_valid), 0);
        chk("fl.inst", inst_o, NOP);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("fl.gone", 32'(out_valid), 0);
        end

        // asynchronous reset mid-cycle
        inst_i = 32'hFFB00093; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        chk("ar.pre_valid", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("ar.valid", 32'(out_valid), 0);
        chk("ar.inst", inst_o, NOP);
        @(negedge clk);
        rst_n = 1;
        idle();

        // random traffic against the reference model
        m_ov = 0; m_trk_v = 0; m_trk_rd = 0; m_exp = model(NOP, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd.valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) chk_fields("rnd", m_exp);
            else chk("rnd.nop", inst_o, NOP);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            inst_i = gen_inst();
            inst_addr_i = $urandom & 32'hFFFF_FFFC;
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            fwd_wen_i = ($urandom_range(0, 1) != 0);
            fwd_rd_i = 5'($urandom_range(0, 3));
            fwd_data_i = $urandom;
            #1;
            d = model(inst_i, inst_addr_i, rs1_data_i, rs2_data_i, fwd_wen_i, fwd_rd_i, fwd_data_i);
            stall = m_trk_v && (d.rs1a == m_trk_rd || d.rs2a == m_trk_rd);
            rdy = (!m_ov || out_ready) && !stall && !flush_i;
            chk("rnd.ready", 32'(in_ready), 32'(rdy));
            chk("rnd.rs1a", 32'(rs1_addr_o), 32'(d.rs1a));
            chk("rnd.rs2a", 32'(rs2_addr_o), 32'(d.rs2a));
            nt_v = !flush_i && m_ov && out_ready && m_exp.mren && m_exp.rd != 0;
            nt_rd = m_exp.rd;
            if (flush_i) m_ov = 0;
            else if (in_valid && rdy) begin m_ov = 1; m_exp = d; end
            else if (m_ov && out_ready) m_ov = 0;
            m_trk_v = nt_v;
            m_trk_rd = nt_rd;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
